// File: rtl/odesa_layer_trainer_pkg.sv
// Shared definitions for the ODESA output-layer trainer.
//   - FSM state encodings for the observation window
//   - f_onehot : true when exactly one bit of a vector is set
//   - f_lr     : x - (x >> s), the "keep" part of a 2^-s learning-rate blend
// Vectors handed to the helpers are zero-extended to 32 bits, so they cover
// neuron counts and operand widths up to 32.
package odesa_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_UPDATE  = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  function automatic logic f_onehot(input logic [31:0] vec);
    return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

  function automatic logic [31:0] f_lr(input logic [31:0] x, input int s);
    return x - (x >> s);
  endfunction

endpackage

// File: rtl/odesa_layer_trainer_if.sv
// Bus between the ODESA layer datapath and its trainer.
//   i_event        : input event strobes, one per synapse channel
//   i_label        : supervisory label, one-hot when valid
//   i_spikeout     : layer spike outputs
//   i_ts           : per-input timestamp surface, slice k = input k
//   i_lv           : per-neuron membrane level at spike, slice n = neuron n
//   i_endof_epochs : freezes training while high
//   o_las / o_gas  : winner / label latched in the current window
//   o_busy         : observation window open
//   o_update       : one-cycle pulse while the learning rule is applied
//   o_weights      : neuron n, input k at (n*P_INPUTS+k)*P_WIDTH
//   o_thresholds   : neuron n at n*(2*P_WIDTH+1)
// master = datapath side, slave = trainer side.
interface odesa_layer_trainer_if #(
  parameter int P_WIDTH   = 9,
  parameter int P_NEURONS = 4,
  parameter int P_INPUTS  = 2
);
  logic [P_INPUTS-1:0]                    i_event;
  logic [P_NEURONS-1:0]                   i_label;
  logic [P_NEURONS-1:0]                   i_spikeout;
  logic [P_INPUTS*P_WIDTH-1:0]            i_ts;
  logic [P_NEURONS*(2*P_WIDTH+1)-1:0]     i_lv;
  logic                                   i_endof_epochs;
  logic                                   o_las;
  logic                                   o_gas;
  logic                                   o_busy;
  logic                                   o_update;
  logic [P_NEURONS*P_INPUTS*P_WIDTH-1:0]  o_weights;
  logic [P_NEURONS*(2*P_WIDTH+1)-1:0]     o_thresholds;

  modport master (
    output i_event, i_label, i_spikeout, i_ts, i_lv, i_endof_epochs,
    input  o_las, o_gas, o_busy, o_update, o_weights, o_thresholds
  );

  modport slave (
    input  i_event, i_label, i_spikeout, i_ts, i_lv, i_endof_epochs,
    output o_las, o_gas, o_busy, o_update, o_weights, o_thresholds
  );
endinterface

// File: rtl/odesa_layer_trainer_onehot_latch.sv
// First-one-hot capture register.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clear        : drop the captured vector (window close / abort)
//   i_en           : capture window is open this cycle
//   i_vec          : candidate vector; zero or multi-hot values are ignored
//   o_valid        : a one-hot vector has been captured
//   o_vec          : the captured vector (meaningful only while o_valid)
module odesa_onehot_latch
  import odesa_pkg::*;
#(
  parameter int P_N = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_clear,
  input  logic           i_en,
  input  logic [P_N-1:0] i_vec,
  output logic           o_valid,
  output logic [P_N-1:0] o_vec
);

  logic take;

  // Only the first qualifying vector in a window is kept.
  assign take = i_en && !o_valid && f_onehot(32'(i_vec));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end else if (take) begin
      o_valid <= 1'b1;
    end
  end

  // The vector itself is only read while o_valid is set, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (take) begin
      o_vec <= i_vec;
    end
  end

endmodule

// File: rtl/odesa_layer_trainer.sv
// Supervised trainer for an ODESA output layer.
// An input event opens an observation window. During COLLECT the first
// one-hot winner spike (with the timestamp surface at that moment) and the
// first one-hot label are latched. After P_PASS_LVL cycles a single UPDATE
// cycle applies reward (winner == label) or punish (label without a matching
// winner) to the weight/threshold banks; HOLD then runs the window out to
// P_WAIT_CLKS cycles, ignoring further events.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of odesa_layer_trainer_if (see that file for signals)
// The interface instance must use the same P_WIDTH/P_NEURONS/P_INPUTS.
module odesa_layer_trainer
  import odesa_pkg::*;
#(
  parameter int                   P_WIDTH       = 9,
  parameter int                   P_NEURONS     = 4,
  parameter int                   P_INPUTS      = 2,
  parameter int                   P_SHIFT       = 3,
  parameter int                   P_DELTA_T     = 15,
  parameter int                   P_MIN_THR     = 16,
  parameter logic [P_WIDTH-1:0]   P_DEFAULT_W   = 'h03F,
  parameter logic [2*P_WIDTH:0]   P_DEFAULT_THR = 'h01FFF,
  parameter int                   P_PASS_LVL    = 7,
  parameter int                   P_WAIT_CLKS   = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  odesa_layer_trainer_if.slave  bus
);

  localparam int LW    = 2 * P_WIDTH + 1;
  localparam int CNT_W = $clog2(P_WAIT_CLKS + 1);
  localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(P_PASS_LVL - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(P_WAIT_CLKS - 1);

  logic [1:0]                  state;
  logic [CNT_W-1:0]            cnt;
  logic                        ev_prev;
  logic                        eoe_prev;
  logic                        ev_start;
  logic                        eoe_rise;
  logic                        win_start;
  logic                        cap_en;
  logic                        win_clear;
  logic                        win_vld;
  logic                        lab_vld;
  logic [P_NEURONS-1:0]        win_vec;
  logic [P_NEURONS-1:0]        lab_vec;
  logic [P_INPUTS*P_WIDTH-1:0] ts_lat;
  logic                        reward;
  logic                        punish;

  logic [LW-1:0]      thr_q [P_NEURONS];
  logic [P_WIDTH-1:0] w_q   [P_NEURONS][P_INPUTS];

  // Reward blend: x - x>>s + target>>s, one bit of headroom for the sum.
  function automatic logic [LW-1:0] f_thr_reward(input logic [LW-1:0] thr,
                                                 input logic [LW-1:0] lv);
    logic [LW:0] sum;
    sum = {1'b0, LW'(f_lr(32'(thr), P_SHIFT))} + {1'b0, lv >> P_SHIFT};
    return LW'(sum);
  endfunction

  function automatic logic [P_WIDTH-1:0] f_w_reward(input logic [P_WIDTH-1:0] w,
                                                    input logic [P_WIDTH-1:0] ts);
    logic [P_WIDTH:0] sum;
    sum = {1'b0, P_WIDTH'(f_lr(32'(w), P_SHIFT))} + {1'b0, ts >> P_SHIFT};
    return P_WIDTH'(sum);
  endfunction

  // Saturating decrement; comparing first also keeps small values from wrapping.
  function automatic logic [LW-1:0] f_thr_punish(input logic [LW-1:0] thr);
    if (thr < LW'(P_MIN_THR + P_DELTA_T)) begin
      return LW'(P_MIN_THR);
    end
    return thr - LW'(P_DELTA_T);
  endfunction

  assign ev_start  = (|bus.i_event) & ~ev_prev;
  assign eoe_rise  = bus.i_endof_epochs & ~eoe_prev;
  assign win_start = (state == ST_IDLE) & ev_start & ~bus.i_endof_epochs;
  // Capture also on the opening edge so a spike coincident with the event counts.
  assign cap_en    = win_start | ((state == ST_COLLECT) & ~eoe_rise);
  assign win_clear = ((state == ST_COLLECT) & eoe_rise) |
                     ((state == ST_HOLD) & (cnt == WAIT_LAST));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ev_prev  <= 1'b0;
      eoe_prev <= 1'b0;
    end else begin
      ev_prev  <= |bus.i_event;
      eoe_prev <= bus.i_endof_epochs;
      case (state)
        ST_IDLE: begin
          if (win_start) begin
            state <= ST_COLLECT;
            cnt   <= '0;
          end
        end
        ST_COLLECT: begin
          if (eoe_rise) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == PASS_LAST) begin
              state <= ST_UPDATE;
            end
          end
        end
        ST_UPDATE: begin
          cnt   <= cnt + 1'b1;
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (cnt == WAIT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  odesa_onehot_latch #(.P_N(P_NEURONS)) u_win_latch (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (win_clear),
    .i_en    (cap_en),
    .i_vec   (bus.i_spikeout),
    .o_valid (win_vld),
    .o_vec   (win_vec)
  );

  odesa_onehot_latch #(.P_N(P_NEURONS)) u_lab_latch (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (win_clear),
    .i_en    (cap_en),
    .i_vec   (bus.i_label),
    .o_valid (lab_vld),
    .o_vec   (lab_vec)
  );

  // Timestamps are taken on exactly the cycle the winner latch fires.
  always_ff @(posedge i_clk) begin
    if (cap_en && !win_vld && f_onehot(32'(bus.i_spikeout))) begin
      ts_lat <= bus.i_ts;
    end
  end

  assign reward = win_vld & lab_vld & (win_vec == lab_vec);
  assign punish = lab_vld & ~reward;

  // UPDATE: at most one neuron changes, selected by the one-hot winner/label.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int n = 0; n < P_NEURONS; n++) begin
        thr_q[n] <= P_DEFAULT_THR;
        for (int k = 0; k < P_INPUTS; k++) begin
          w_q[n][k] <= P_DEFAULT_W;
        end
      end
    end else if (state == ST_UPDATE) begin
      for (int n = 0; n < P_NEURONS; n++) begin
        if (reward && win_vec[n]) begin
          thr_q[n] <= f_thr_reward(thr_q[n], bus.i_lv[n*LW +: LW]);
          for (int k = 0; k < P_INPUTS; k++) begin
            w_q[n][k] <= f_w_reward(w_q[n][k], ts_lat[k*P_WIDTH +: P_WIDTH]);
          end
        end else if (punish && lab_vec[n]) begin
          thr_q[n] <= f_thr_punish(thr_q[n]);
        end
      end
    end
  end

  assign bus.o_las    = win_vld;
  assign bus.o_gas    = lab_vld;
  assign bus.o_busy   = (state != ST_IDLE);
  assign bus.o_update = (state == ST_UPDATE);

  for (genvar gn = 0; gn < P_NEURONS; gn++) begin : g_neuron
    assign bus.o_thresholds[gn*LW +: LW] = thr_q[gn];
    for (genvar gk = 0; gk < P_INPUTS; gk++) begin : g_syn
      assign bus.o_weights[(gn*P_INPUTS+gk)*P_WIDTH +: P_WIDTH] = w_q[gn][gk];
    end
  end

endmodule

// File: tb/tb_odesa_layer_trainer.sv
// Directed bench for odesa_layer_trainer (default parameters).
module tb_odesa_layer_trainer;

  localparam logic [17:0] TS_JUNK = {9'h1AA, 9'h155};

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [8:0]  exp_w   [8];
  logic [18:0] exp_thr [4];

  bit   upd_seen;
  bit   busy_seen;
  logic las_u;
  logic gas_u;

  odesa_layer_trainer_if #(.P_WIDTH(9), .P_NEURONS(4), .P_INPUTS(2)) bus ();

  odesa_layer_trainer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_exp();
    for (int i = 0; i < 8; i++) exp_w[i] = 9'h03F;
    for (int i = 0; i < 4; i++) exp_thr[i] = 19'h01FFF;
  endtask

  task automatic check_banks(input string tag);
    logic [71:0] pw;
    logic [75:0] pt;
    for (int i = 0; i < 8; i++) pw[i*9 +: 9] = exp_w[i];
    for (int i = 0; i < 4; i++) pt[i*19 +: 19] = exp_thr[i];
    check_eq({tag, "_weights"}, 128'(bus.o_weights), 128'(pw));
    check_eq({tag, "_thresholds"}, 128'(bus.o_thresholds), 128'(pt));
  endtask

  task automatic idle_inputs();
    bus.i_event        = 2'b00;
    bus.i_label        = 4'b0000;
    bus.i_spikeout     = 4'b0000;
    bus.i_ts           = 18'h0;
    bus.i_endof_epochs = 1'b0;
  endtask

  // Cycle 0 carries the event; a cycle number of -1 disables that stimulus.
  task automatic run_window(input logic [3:0] spk_a, input int cyc_a, input logic [17:0] ts_a,
                            input logic [3:0] spk_b, input int cyc_b, input logic [17:0] ts_b,
                            input logic [3:0] lab, input int cyc_l, input int eoe_from);
    upd_seen  = 1'b0;
    busy_seen = 1'b0;
    las_u     = 1'b0;
    gas_u     = 1'b0;
    for (int c = 0; c < 16; c++) begin
      bus.i_event        = (c == 0) ? 2'b01 : 2'b00;
      bus.i_spikeout     = (c == cyc_a) ? spk_a : (c == cyc_b) ? spk_b : 4'b0000;
      bus.i_ts           = (c == cyc_a) ? ts_a : (c == cyc_b) ? ts_b : TS_JUNK;
      bus.i_label        = (c == cyc_l) ? lab : 4'b0000;
      bus.i_endof_epochs = (eoe_from >= 0) && (c >= eoe_from);
      @(posedge clk); #1;
      if (bus.o_busy) busy_seen = 1'b1;
      if (bus.o_update) begin
        upd_seen = 1'b1;
        las_u    = bus.o_las;
        gas_u    = bus.o_gas;
      end
      if (c > 0 && !bus.o_busy) break;
    end
    check_eq("window_closed", 128'(bus.o_busy), 128'(0));
    idle_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    // lv0 = 0x02000, lv1 = 0x00058, lv3 = 0x00800
    bus.i_lv = {19'h00800, 19'h00000, 19'h00058, 19'h02000};
    reset_exp();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check_eq("rst_las", 128'(bus.o_las), 128'(0));
    check_eq("rst_gas", 128'(bus.o_gas), 128'(0));
    check_eq("rst_busy", 128'(bus.o_busy), 128'(0));
    check_eq("rst_update", 128'(bus.o_update), 128'(0));
    check_banks("rst");

    // Reward on neuron 0, spike at cycle 2, label at cycle 3
    run_window(4'b0001, 2, {9'h080, 9'h100}, 4'b0000, -1, 18'h0, 4'b0001, 3, -1);
    check_eq("t1_update_seen", 128'(upd_seen), 128'(1));
    check_eq("t1_las_at_update", 128'(las_u), 128'(1));
    check_eq("t1_gas_at_update", 128'(gas_u), 128'(1));
    check_eq("t1_thr0", 128'(bus.o_thresholds[18:0]), 128'(19'h02000));
    check_eq("t1_w00", 128'(bus.o_weights[8:0]), 128'(9'h058));
    check_eq("t1_w01", 128'(bus.o_weights[17:9]), 128'(9'h048));
    exp_thr[0] = 19'h02000;
    exp_w[0]   = 9'h058;
    exp_w[1]   = 9'h048;
    check_banks("t1");

    // Mismatch: winner 1, label 2 -> punish neuron 2
    run_window(4'b0010, 1, 18'h0, 4'b0000, -1, 18'h0, 4'b0100, 2, -1);
    check_eq("t2_update_seen", 128'(upd_seen), 128'(1));
    exp_thr[2] = 19'h01FF0;
    check_banks("t2");

    // Label only -> punish neuron 3
    run_window(4'b0000, -1, 18'h0, 4'b0000, -1, 18'h0, 4'b1000, 4, -1);
    check_eq("t3_las_at_update", 128'(las_u), 128'(0));
    check_eq("t3_gas_at_update", 128'(gas_u), 128'(1));
    exp_thr[3] = 19'h01FF0;
    check_banks("t3a");

    // Spike only -> no change
    run_window(4'b0001, 1, 18'h0, 4'b0000, -1, 18'h0, 4'b0000, -1, -1);
    check_eq("t3b_las_at_update", 128'(las_u), 128'(1));
    check_eq("t3b_gas_at_update", 128'(gas_u), 128'(0));
    check_banks("t3b");

    // Training frozen mid-COLLECT: window aborts, no update, latches cleared
    run_window(4'b0001, 1, 18'h0, 4'b0000, -1, 18'h0, 4'b0001, 1, 2);
    check_eq("abort_no_update", 128'(upd_seen), 128'(0));
    check_eq("abort_las", 128'(bus.o_las), 128'(0));
    check_eq("abort_gas", 128'(bus.o_gas), 128'(0));
    check_banks("abort");

    // Reward neuron 1 with lv1=0x58, ts=0: thr1 = 0x1C00 + 0xB = 0x1C0B
    run_window(4'b0010, 1, 18'h0, 4'b0000, -1, 18'h0, 4'b0010, 1, -1);
    exp_thr[1] = 19'h01C0B;
    exp_w[2]   = 9'h038;
    exp_w[3]   = 9'h038;
    check_banks("t4_reward");

    // 477 punishes: 0x1C0B - 477*15 = 0x18
    for (int i = 0; i < 477; i++) begin
      run_window(4'b0000, -1, 18'h0, 4'b0000, -1, 18'h0, 4'b0010, 1, -1);
    end
    check_eq("t4_thr1_preload", 128'(bus.o_thresholds[37:19]), 128'(19'h00018));
    run_window(4'b0000, -1, 18'h0, 4'b0000, -1, 18'h0, 4'b0010, 2, -1);
    check_eq("t4_thr1_sat", 128'(bus.o_thresholds[37:19]), 128'(19'h00010));
    run_window(4'b0000, -1, 18'h0, 4'b0000, -1, 18'h0, 4'b0010, 2, -1);
    check_eq("t4_thr1_hold", 128'(bus.o_thresholds[37:19]), 128'(19'h00010));
    exp_thr[1] = 19'h00010;
    check_banks("t4");

    // Multi-hot at cycle 1 ignored; winner 3 at cycle 3 with label 3
    run_window(4'b0011, 1, {9'h1FF, 9'h1FF}, 4'b1000, 3, {9'h0F0, 9'h040}, 4'b1000, 3, -1);
    check_eq("t5_las_at_update", 128'(las_u), 128'(1));
    check_eq("t5_thr3", 128'(bus.o_thresholds[75:57]), 128'(19'h01CF2));
    exp_thr[3] = 19'h01CF2;
    exp_w[6]   = 9'h040;
    exp_w[7]   = 9'h056;
    check_banks("t5");

    // Reset in the middle of COLLECT
    bus.i_event = 2'b10;
    @(posedge clk); #1;
    bus.i_event    = 2'b00;
    bus.i_spikeout = 4'b0001;
    bus.i_label    = 4'b0001;
    @(posedge clk); #1;
    idle_inputs();
    check_eq("t6_busy_before", 128'(bus.o_busy), 128'(1));
    check_eq("t6_las_before", 128'(bus.o_las), 128'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("t6_busy", 128'(bus.o_busy), 128'(0));
    check_eq("t6_las", 128'(bus.o_las), 128'(0));
    check_eq("t6_gas", 128'(bus.o_gas), 128'(0));
    check_eq("t6_update", 128'(bus.o_update), 128'(0));
    reset_exp();
    check_banks("t6");

    // Frozen training: events must not open a window
    for (int i = 0; i < 3; i++) begin
      run_window(4'b0001, 1, 18'h0, 4'b0000, -1, 18'h0, 4'b0001, 1, 0);
      check_eq("t6_eoe_busy", 128'(busy_seen), 128'(0));
      check_eq("t6_eoe_update", 128'(upd_seen), 128'(0));
    end
    check_banks("t6_eoe");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
